// File: rtl/fifo_serial_tx_if.sv
// Handshake bundle between the upstream FIFO / control side and fifo_serial_tx.
// The transmitter binds to the slave modport; whoever feeds it uses master.
interface fifo_serial_tx_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  enable;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_remove;
  logic                  tx;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output enable,
    output fifo_empty,
    output fifo_dout,
    input  fifo_remove,
    input  tx,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  enable,
    input  fifo_empty,
    input  fifo_dout,
    output fifo_remove,
    output tx,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// Pops words from a single-clock FIFO and sends each as an async serial frame:
// start bit, DATA_WIDTH bits LSB first, optional even parity, one stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for enable and a non-empty FIFO
// POP    | one-cycle pop request; FIFO registers fifo_dout on the exit edge
// LOAD   | capture fifo_dout into the shift register and compute parity
// START  | line low for one bit time
// DATA   | data bits LSB first, one bit time each
// PARITY | even-parity bit for one bit time (only when PARITY_EN=1)
// STOP   | line high for one bit time; frame_done on the last cycle
module fifo_serial_tx #(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_serial_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  remove_q, remove_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      remove_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      remove_q <= remove_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    baud_end = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (bus.enable && !bus.fifo_empty) state_d = S_POP;
      end
      // An empty flag seen during the pop means the word was flushed upstream.
      S_POP: begin
        state_d = bus.fifo_empty ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        shift_d  = bus.fifo_dout;
        parity_d = ^bus.fifo_dout;
        cnt_d    = '0;
        bit_d    = '0;
        state_d  = S_START;
      end
      S_START: begin
        if (baud_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          cnt_d   = '0;
          state_d = (bus.enable && !bus.fifo_empty) ? S_POP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up exactly with the state they describe.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    remove_d = (state_d == S_POP);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_STOP) && (cnt_d == CNT_LAST);
  end

  assign bus.tx          = tx_q;
  assign bus.fifo_remove = remove_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: one instance without parity, one with parity,
// each fed by its own small FIFO model; outputs are checked cycle by cycle.
module tb_fifo_serial_tx;

  localparam int DW  = 4;
  localparam int CPB = 4;

  logic clk;
  logic rst_n;

  fifo_serial_tx_if #(.DATA_WIDTH(DW)) ifc0 ();
  fifo_serial_tx_if #(.DATA_WIDTH(DW)) ifc1 ();

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc0.slave)
  );

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO models: words written by the test, popped on sampled remove.
  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  logic flush0 = 1'b0;

  assign ifc0.fifo_empty = flush0 || (wr0 == rd0);
  assign ifc1.fifo_empty = (wr1 == rd1);

  always @(posedge clk) begin
    if (ifc0.fifo_remove && !ifc0.fifo_empty) begin
      ifc0.fifo_dout <= mem0[rd0 % 16];
      rd0 <= rd0 + 1;
    end else if (flush0) begin
      rd0 <= wr0;
    end
  end

  always @(posedge clk) begin
    if (ifc1.fifo_remove && !ifc1.fifo_empty) begin
      ifc1.fifo_dout <= mem1[rd1 % 16];
      rd1 <= rd1 + 1;
    end
  end

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit            sel;
    logic [DW-1:0] word;
    int            nb;
    logic [11:0]   bits;
  } vec_t;

  vec_t tbl [7];

  task automatic push(input bit sel, input logic [DW-1:0] w);
    if (sel) begin
      mem1[wr1 % 16] = w;
      wr1 = wr1 + 1;
    end else begin
      mem0[wr0 % 16] = w;
      wr0 = wr0 + 1;
    end
  endtask

  task automatic set_en(input bit sel, input logic v);
    if (sel) ifc1.enable = v;
    else     ifc0.enable = v;
  endtask

  // exp_v = {tx, fifo_remove, busy, frame_done}
  task automatic expect_cycle(input bit sel, input string name, input logic [3:0] exp_v);
    logic [3:0] act;
    @(negedge clk);
    act = sel ? {ifc1.tx, ifc1.fifo_remove, ifc1.busy, ifc1.frame_done}
              : {ifc0.tx, ifc0.fifo_remove, ifc0.busy, ifc0.frame_done};
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s (inst%0d t=%0t): tx/rem/busy/done got %b need %b",
                  name, sel, $time, act, exp_v);
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic void frame_bits(input logic [DW-1:0] w, input bit par,
                                     output logic [11:0] bits, output int nb);
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = w[i];
    nb = DW + 1;
    if (par) begin
      bits[nb] = ^w;
      nb = nb + 1;
    end
    bits[nb] = 1'b1;
    nb = nb + 1;
  endfunction

  // Checks POP, LOAD and every bit-time cycle of one frame. Next negedge must
  // be the POP cycle on entry. drop_at clears enable after that cycle index;
  // abort_at returns before checking that cycle index.
  task automatic expect_frame(input bit sel, input logic [11:0] bits, input int nb,
                              input int drop_at, input int abort_at);
    int total;
    int b;
    int ph;
    total = 2 + nb * CPB;
    for (int c = 0; c < total; c++) begin
      if (c == abort_at) return;
      if (c == 0) expect_cycle(sel, "pop", 4'b1110);
      else if (c == 1) expect_cycle(sel, "load", 4'b1010);
      else begin
        b  = (c - 2) / CPB;
        ph = (c - 2) % CPB;
        expect_cycle(sel, $sformatf("bit%0d", b),
                     {bits[b], 1'b0, 1'b1, (b == nb - 1) && (ph == CPB - 1)});
      end
      if (c == drop_at) set_en(sel, 1'b0);
    end
  endtask

  task automatic expect_idle(input bit sel, input string name, input int n);
    for (int i = 0; i < n; i++) expect_cycle(sel, name, 4'b1000);
  endtask

  initial begin
    logic [11:0]   bits;
    int            nb;
    logic [DW-1:0] words [3];
    bit            sel;
    int            n;

    tbl[0] = '{1'b0, 4'hA, 6, 12'h034};
    tbl[1] = '{1'b1, 4'h7, 7, 12'h06E};
    tbl[2] = '{1'b0, 4'h0, 6, 12'h020};
    tbl[3] = '{1'b0, 4'hF, 6, 12'h03E};
    tbl[4] = '{1'b1, 4'h0, 7, 12'h040};
    tbl[5] = '{1'b1, 4'h5, 7, 12'h04A};
    tbl[6] = '{1'b1, 4'hE, 7, 12'h07C};

    rst_n = 1'b0;
    ifc0.enable = 1'b1;
    ifc1.enable = 1'b1;

    expect_cycle(0, "reset", 4'b1000);
    expect_cycle(1, "reset", 4'b1000);
    #1 rst_n = 1'b1;
    expect_idle(0, "idle_empty", 3);
    expect_idle(1, "idle_empty", 2);

    // Directed frames, one word each.
    for (int i = 0; i < 7; i++) begin
      push(tbl[i].sel, tbl[i].word);
      expect_frame(tbl[i].sel, tbl[i].bits, tbl[i].nb, -1, -1);
      expect_idle(tbl[i].sel, "after_frame", 2);
    end

    // Three queued words: stop bit is followed directly by POP, LOAD, START.
    push(0, 4'h3); push(0, 4'hC); push(0, 4'h9);
    frame_bits(4'h3, 0, bits, nb); expect_frame(0, bits, nb, -1, -1);
    frame_bits(4'hC, 0, bits, nb); expect_frame(0, bits, nb, -1, -1);
    frame_bits(4'h9, 0, bits, nb); expect_frame(0, bits, nb, -1, -1);
    expect_idle(0, "b2b_idle", 3);

    // enable dropped mid-DATA: frame completes, second word stays queued.
    push(1, 4'h6); push(1, 4'hB);
    frame_bits(4'h6, 1, bits, nb); expect_frame(1, bits, nb, 2 + CPB + 3, -1);
    expect_idle(1, "en_low_hold", 10);
    set_en(1, 1'b1);
    frame_bits(4'hB, 1, bits, nb); expect_frame(1, bits, nb, -1, -1);
    expect_idle(1, "en_resume_idle", 2);

    // Reset in the middle of DATA: line goes high at once, next word sent whole.
    push(0, 4'h5); push(0, 4'hD);
    frame_bits(4'h5, 0, bits, nb); expect_frame(0, bits, nb, -1, 2 + CPB + 6);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc0.tx, ifc0.fifo_remove, ifc0.busy, ifc0.frame_done} === 4'b1000) passes++;
    else $display("FAIL rst_async: tx/rem/busy/done got %b need 1000",
                  {ifc0.tx, ifc0.fifo_remove, ifc0.busy, ifc0.frame_done});
    @(negedge clk);
    #1 rst_n = 1'b1;
    frame_bits(4'hD, 0, bits, nb); expect_frame(0, bits, nb, -1, -1);
    expect_idle(0, "post_reset_idle", 3);

    // Upstream flush while in POP: straight back to IDLE, no frame.
    push(0, 4'h1);
    expect_cycle(0, "flush_pop", 4'b1110);
    flush0 = 1'b1;
    expect_idle(0, "flush_idle", 8 * CPB);
    flush0 = 1'b0;
    expect_idle(0, "flush_after", 2);

    // Randomized bursts against the frame model.
    for (int it = 0; it < 24; it++) begin
      sel = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        words[k] = DW'($urandom);
        push(sel, words[k]);
      end
      for (int k = 0; k < n; k++) begin
        frame_bits(words[k], sel, bits, nb);
        expect_frame(sel, bits, nb, -1, -1);
      end
      expect_idle(sel, "rand_idle", int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
